// File: rtl/pe_pkg.sv
// Shared definitions for the RV32I processing-element controller:
// opcodes, FSM states, datapath select encodings and branch resolution.
package pe_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        FETCH, DECODE, OPER, EXEC, MEM, WB, PCUPD
    } state_e;

    localparam logic [4:0] ALU_ADD   = 5'b00000;
    localparam logic [4:0] ALU_SUB   = 5'b01000;
    localparam logic [4:0] ALU_SLT   = 5'b00010;
    localparam logic [4:0] ALU_SLTU  = 5'b00011;
    localparam logic [4:0] ALU_PASSB = 5'b10000;

    localparam logic [1:0] ASEL_RS1  = 2'd0;
    localparam logic [1:0] ASEL_PC   = 2'd1;
    localparam logic [1:0] ASEL_ZERO = 2'd2;

    localparam logic [1:0] BSEL_RS2  = 2'd0;
    localparam logic [1:0] BSEL_IMM  = 2'd1;
    localparam logic [1:0] BSEL_FOUR = 2'd2;

    localparam logic [1:0] OSEL_ALU  = 2'd0;
    localparam logic [1:0] OSEL_MEM  = 2'd1;
    localparam logic [1:0] OSEL_PC4  = 2'd2;

    function automatic logic is_known_op(input logic [6:0] o);
        case (o)
            OP_IMM, OP, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // The ALU compares via SUB/SLT/SLTU, so every condition reduces to the zero flag.
    function automatic logic branch_taken(input logic [2:0] f3, input logic zero);
        case (f3)
            3'b000, 3'b101, 3'b111: return zero;
            3'b001, 3'b100, 3'b110: return !zero;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pe_imm_gen.sv
// Combinational immediate formatter: turns raw decoder immediate fields into
// the 32-bit operand for the instruction format implied by the opcode.
module pe_imm_gen
    import pe_pkg::*;
(
    input  logic [6:0]  op_i,
    input  logic [2:0]  funct3_i,
    input  logic [11:0] imm12_i,
    input  logic [19:0] immhi_i,
    output logic [31:0] imm_o
);

    always_comb begin
        imm_o = '0;
        case (op_i)
            OP_IMM: begin
                // Shift-immediates carry only a shift amount; upper bits hold funct7.
                if (funct3_i == 3'b001 || funct3_i == 3'b101)
                    imm_o = {27'b0, imm12_i[4:0]};
                else
                    imm_o = {{20{imm12_i[11]}}, imm12_i};
            end
            LOAD, STORE, JALR: imm_o = {{20{imm12_i[11]}}, imm12_i};
            BRANCH:            imm_o = {{19{imm12_i[11]}}, imm12_i, 1'b0};
            LUI, AUIPC:        imm_o = {immhi_i, 12'h000};
            JAL:               imm_o = {{11{immhi_i[19]}}, immhi_i, 1'b0};
            default:           imm_o = '0;
        endcase
    end

endmodule

// File: rtl/pe_controller.sv
// Multi-cycle control FSM of the RV32I processing element: sequences fetch,
// decode, operand load, ALU, memory, writeback and PC update.
module pe_controller
    import pe_pkg::*;
#(
    parameter int PC_STEP = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic [11:0] imm12,
    input  logic [19:0] immhi,
    input  logic        decodeComplete,
    input  logic        dataReady,
    input  logic        ALUcomplete,
    input  logic [31:0] ALURes,
    input  logic        ALU0,
    input  logic        mem_ack,
    input  logic [31:0] PCin,
    output logic [31:0] PCout,
    output logic [4:0]  ALUsel,
    output logic [1:0]  Asel,
    output logic [1:0]  Bsel,
    output logic [1:0]  Osel,
    output logic [4:0]  rdOut,
    output logic        rdWrite,
    output logic        Aenable,
    output logic        Benable,
    output logic        IRenable,
    output logic        reg_reset,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic        reg_select,
    output logic [31:0] immvalue,
    output logic [4:0]  rs1Out,
    output logic [4:0]  rs2Out
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, maddr_q, maddr_d, imm_q, imm_d, alu_q, alu_d;
    logic [4:0]  rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [6:0]  op_q, op_d;
    logic [2:0]  f3_q, f3_d;
    logic        alt_q, alt_d, taken_q, taken_d;
    logic [31:0] imm_fmt;
    logic        unused_funct7;

    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    pe_imm_gen u_imm (
        .op_i     (op),
        .funct3_i (funct3),
        .imm12_i  (imm12),
        .immhi_i  (immhi),
        .imm_o    (imm_fmt)
    );

    function automatic logic [4:0] alu_sel_f(input logic [6:0] o, input logic [2:0] f3,
                                             input logic alt);
        case (o)
            OP:     return {1'b0, alt, f3};
            OP_IMM: return {1'b0, (f3 == 3'b101) ? alt : 1'b0, f3};
            BRANCH: begin
                case (f3[2:1])
                    2'b00:   return ALU_SUB;
                    2'b11:   return ALU_SLTU;
                    default: return ALU_SLT;
                endcase
            end
            LUI:     return ALU_PASSB;
            default: return ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: if (decodeComplete) begin
                if (!is_known_op(op)) state_d = FETCH;
                else if (op == JAL)   state_d = WB;
                else                  state_d = OPER;
            end
            OPER:   if (dataReady) state_d = EXEC;
            EXEC:   if (ALUcomplete) begin
                if (op_q == LOAD || op_q == STORE) state_d = MEM;
                else if (op_q == BRANCH)           state_d = PCUPD;
                else                               state_d = WB;
            end
            MEM:    if (mem_ack) state_d = (op_q == LOAD) ? WB : PCUPD;
            WB:     state_d = PCUPD;
            PCUPD:  state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Strobes are gated by reset so nothing fires while FETCH is held in reset.
    always_comb begin
        IRenable   = 1'b0;
        Aenable    = 1'b0;
        Benable    = 1'b0;
        rdWrite    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_select = 1'b0;
        ALUsel     = ALU_ADD;
        Asel       = ASEL_RS1;
        Bsel       = BSEL_RS2;
        Osel       = OSEL_ALU;
        if (!reset) begin
            case (state_q)
                FETCH: IRenable = 1'b1;
                OPER: begin
                    Aenable = 1'b1;
                    Benable = 1'b1;
                end
                EXEC: begin
                    ALUsel = alu_sel_f(op_q, f3_q, alt_q);
                    Asel   = (op_q == AUIPC) ? ASEL_PC : (op_q == LUI) ? ASEL_ZERO : ASEL_RS1;
                    Bsel   = (op_q == OP || op_q == BRANCH) ? BSEL_RS2 : BSEL_IMM;
                end
                MEM: begin
                    if (op_q == LOAD) begin
                        mem_read = 1'b1;
                    end else begin
                        mem_write  = 1'b1;
                        reg_select = 1'b1;
                    end
                end
                WB: begin
                    rdWrite = (rd_q != 5'd0);
                    Osel    = (op_q == LOAD) ? OSEL_MEM :
                              (op_q == JAL || op_q == JALR) ? OSEL_PC4 : OSEL_ALU;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        pc_d    = pc_q;
        maddr_d = maddr_q;
        imm_d   = imm_q;
        alu_d   = alu_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        op_d    = op_q;
        f3_d    = f3_q;
        alt_d   = alt_q;
        taken_d = taken_q;
        case (state_q)
            DECODE: if (decodeComplete) begin
                op_d  = op;
                f3_d  = funct3;
                alt_d = funct7[5];
                rd_d  = rd;
                rs1_d = rs1;
                rs2_d = rs2;
                imm_d = imm_fmt;
                if (!is_known_op(op)) pc_d = PCin + 32'(PC_STEP);
            end
            EXEC: if (ALUcomplete) begin
                alu_d   = ALURes;
                taken_d = branch_taken(f3_q, ALU0);
                if (op_q == LOAD || op_q == STORE) maddr_d = ALURes;
            end
            PCUPD: begin
                case (op_q)
                    BRANCH:  pc_d = taken_q ? PCin + imm_q : PCin + 32'(PC_STEP);
                    JAL:     pc_d = PCin + imm_q;
                    JALR:    pc_d = alu_q & ~32'd1;
                    default: pc_d = PCin + 32'(PC_STEP);
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= '0;
            maddr_q <= '0;
            imm_q   <= '0;
            alu_q   <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            op_q    <= '0;
            f3_q    <= '0;
            alt_q   <= 1'b0;
            taken_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            maddr_q <= maddr_d;
            imm_q   <= imm_d;
            alu_q   <= alu_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            op_q    <= op_d;
            f3_q    <= f3_d;
            alt_q   <= alt_d;
            taken_q <= taken_d;
        end
    end

    assign PCout       = pc_q;
    assign mem_address = maddr_q;
    assign immvalue    = imm_q;
    assign rdOut       = rd_q;
    assign rs1Out      = rs1_q;
    assign rs2Out      = rs2_q;
    assign reg_reset   = reset;

endmodule

// File: tb/tb_pe_controller.sv
// Self-checking bench for pe_controller: directed instruction scenarios plus
// randomized instructions and handshake stalls checked against a behavioural model.
module tb_pe_controller;

    localparam logic [6:0] O_IMM   = 7'b0010011;
    localparam logic [6:0] O_OP    = 7'b0110011;
    localparam logic [6:0] O_LOAD  = 7'b0000011;
    localparam logic [6:0] O_STORE = 7'b0100011;
    localparam logic [6:0] O_BR    = 7'b1100011;
    localparam logic [6:0] O_LUI   = 7'b0110111;
    localparam logic [6:0] O_AUIPC = 7'b0010111;
    localparam logic [6:0] O_JAL   = 7'b1101111;
    localparam logic [6:0] O_JALR  = 7'b1100111;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  op, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;
    logic [11:0] imm12;
    logic [19:0] immhi;
    logic        decodeComplete, dataReady, ALUcomplete, ALU0, mem_ack;
    logic [31:0] ALURes, PCin;
    logic [31:0] PCout, mem_address, immvalue;
    logic [4:0]  ALUsel, rdOut, rs1Out, rs2Out;
    logic [1:0]  Asel, Bsel, Osel;
    logic        rdWrite, Aenable, Benable, IRenable, reg_reset;
    logic        mem_read, mem_write, reg_select;

    int n_checks = 0;
    int n_fail   = 0;

    logic        ob_start, ob_dec_quiet, ob_oper, ob_exec_stable, ob_mem_held, ob_timeout, ob_stray;
    logic [4:0]  ob_alusel, ob_wr_rd, ob_rs1, ob_rs2;
    logic [1:0]  ob_asel, ob_bsel, ob_osel;
    logic        ob_mrd, ob_mwr, ob_rsel;
    logic [31:0] ob_maddr, ob_pc, ob_imm;
    int          ob_nwr;

    always #5 clk = ~clk;

    pe_controller #(.PC_STEP(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm12(imm12), .immhi(immhi),
        .decodeComplete(decodeComplete), .dataReady(dataReady), .ALUcomplete(ALUcomplete),
        .ALURes(ALURes), .ALU0(ALU0), .mem_ack(mem_ack), .PCin(PCin), .PCout(PCout),
        .ALUsel(ALUsel), .Asel(Asel), .Bsel(Bsel), .Osel(Osel), .rdOut(rdOut),
        .rdWrite(rdWrite), .Aenable(Aenable), .Benable(Benable), .IRenable(IRenable),
        .reg_reset(reg_reset), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .reg_select(reg_select), .immvalue(immvalue),
        .rs1Out(rs1Out), .rs2Out(rs2Out)
    );

    // ---------------- behavioural reference model ----------------
    function automatic logic known(input logic [6:0] o);
        return o inside {O_IMM, O_OP, O_LOAD, O_STORE, O_BR, O_LUI, O_AUIPC, O_JAL, O_JALR};
    endfunction

    function automatic logic m_writes(input logic [6:0] o);
        return o inside {O_IMM, O_OP, O_LOAD, O_LUI, O_AUIPC, O_JAL, O_JALR};
    endfunction

    function automatic logic [31:0] m_imm(input logic [6:0] o, input logic [2:0] f3,
                                          input logic [11:0] i12, input logic [19:0] ihi);
        int v;
        v = 0;
        case (o)
            O_IMM:  if (f3 == 3'd1 || f3 == 3'd5) v = int'(i12[4:0]); else v = $signed(i12);
            O_LOAD, O_STORE, O_JALR: v = $signed(i12);
            O_BR:   v = $signed({i12, 1'b0});
            O_LUI, O_AUIPC: v = int'(ihi) * 4096;
            O_JAL:  v = $signed({ihi, 1'b0});
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic logic [4:0] m_alusel(input logic [6:0] o, input logic [2:0] f3,
                                            input logic [6:0] f7);
        case (o)
            O_OP:  return {1'b0, f7[5], f3};
            O_IMM: return {1'b0, (f3 == 3'd5) && f7[5], f3};
            O_BR:  return (f3 < 3'd2) ? 5'd8 : (f3 < 3'd6) ? 5'd2 : 5'd3;
            O_LUI: return 5'd16;
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [1:0] m_asel(input logic [6:0] o);
        return (o == O_AUIPC) ? 2'd1 : (o == O_LUI) ? 2'd2 : 2'd0;
    endfunction

    function automatic logic [1:0] m_bsel(input logic [6:0] o);
        return (o == O_OP || o == O_BR) ? 2'd0 : 2'd1;
    endfunction

    function automatic logic [1:0] m_osel(input logic [6:0] o);
        return (o == O_LOAD) ? 2'd1 : (o == O_JAL || o == O_JALR) ? 2'd2 : 2'd0;
    endfunction

    function automatic logic [31:0] m_pc(input logic [6:0] o, input logic [2:0] f3,
                                         input logic [31:0] imm, input logic [31:0] pc,
                                         input logic [31:0] ar, input logic z);
        logic taken;
        case (o)
            O_BR: begin
                case (f3)
                    3'd0: taken = z;
                    3'd1: taken = !z;
                    3'd4, 3'd6: taken = !z;
                    default: taken = z;
                endcase
                return taken ? pc + imm : pc + 32'd4;
            end
            O_JAL:  return pc + imm;
            O_JALR: return ar & 32'hFFFF_FFFE;
            default: return pc + 32'd4;
        endcase
    endfunction

    function automatic logic [6:0] kind2op(input int k);
        case (k)
            0: return O_OP;    1: return O_IMM;   2: return O_LOAD;
            3: return O_STORE; 4: return O_BR;    5: return O_LUI;
            6: return O_AUIPC; 7: return O_JAL;   8: return O_JALR;
            default: return 7'b1111111;
        endcase
    endfunction

    // ---------------- driver: runs one instruction, records observations ----------------
    // Entered at a falling edge while the DUT is fetching; returns at the next fetch.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                             input logic [11:0] i12, input logic [19:0] ihi,
                             input logic [31:0] pc, input logic [31:0] ar, input logic z,
                             input int dd, input int dop, input int dex, input int dm);
        logic done;
        ob_start = IRenable; ob_dec_quiet = 1; ob_oper = 1; ob_exec_stable = 1;
        ob_mem_held = 1; ob_timeout = 0; ob_stray = 0; ob_nwr = 0; ob_wr_rd = 0; ob_osel = 0;
        ob_alusel = 0; ob_asel = 0; ob_bsel = 0; ob_mrd = 0; ob_mwr = 0; ob_rsel = 0; ob_maddr = 0;
        op = o; funct3 = f3; funct7 = f7; rs1 = a; rs2 = b; rd = d; imm12 = i12; immhi = ihi;
        PCin = pc; ALURes = ar; ALU0 = z;
        decodeComplete = 0; dataReady = 0; ALUcomplete = 0; mem_ack = 0;
        @(negedge clk);
        repeat (dd) begin
            if (IRenable || Aenable || rdWrite) ob_dec_quiet = 0;
            @(negedge clk);
        end
        decodeComplete = 1; @(negedge clk); decodeComplete = 0;
        if (known(o) && o != O_JAL) begin
            repeat (dop) begin
                if (!(Aenable && Benable)) ob_oper = 0;
                @(negedge clk);
            end
            if (!(Aenable && Benable)) ob_oper = 0;
            dataReady = 1; @(negedge clk); dataReady = 0;
            ob_alusel = ALUsel; ob_asel = Asel; ob_bsel = Bsel;
            repeat (dex) begin
                @(negedge clk);
                if ({ALUsel, Asel, Bsel} !== {ob_alusel, ob_asel, ob_bsel}) ob_exec_stable = 0;
            end
            ALUcomplete = 1; @(negedge clk); ALUcomplete = 0;
            if (o == O_LOAD || o == O_STORE) begin
                ob_mrd = mem_read; ob_mwr = mem_write; ob_rsel = reg_select; ob_maddr = mem_address;
                repeat (dm) begin
                    @(negedge clk);
                    if ({mem_read, mem_write, reg_select} !== {ob_mrd, ob_mwr, ob_rsel}) ob_mem_held = 0;
                end
                mem_ack = 1; @(negedge clk); mem_ack = 0;
            end
        end
        done = 0;
        for (int i = 0; i < 8 && !done; i++) begin
            if (IRenable) done = 1;
            else begin
                if (rdWrite) begin ob_nwr++; ob_wr_rd = rdOut; ob_osel = Osel; end
                if (mem_read || mem_write) ob_stray = 1;
                @(negedge clk);
            end
        end
        ob_timeout = !done;
        ob_pc = PCout; ob_imm = immvalue; ob_rs1 = rs1Out; ob_rs2 = rs2Out;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1;
        op = 0; funct3 = 0; funct7 = 0; rs1 = 0; rs2 = 0; rd = 0; imm12 = 0; immhi = 0;
        decodeComplete = 0; dataReady = 0; ALUcomplete = 0; ALURes = 0; ALU0 = 0;
        mem_ack = 0; PCin = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({PCout, mem_address, immvalue} !== 96'd0) begin
            n_fail++; $display("FAIL reset_regs: PCout=%h mem_address=%h immvalue=%h, want 0", PCout, mem_address, immvalue);
        end
        n_checks++;
        if ({IRenable, Aenable, Benable, rdWrite, mem_read, mem_write, reg_select} !== 7'd0) begin
            n_fail++; $display("FAIL reset_strobes: got %b want 0000000",
                {IRenable, Aenable, Benable, rdWrite, mem_read, mem_write, reg_select});
        end
        n_checks++;
        if ({ALUsel, Asel, Bsel, Osel} !== 11'd0 || reg_reset !== 1'b1) begin
            n_fail++; $display("FAIL reset_sel: selects=%h reg_reset=%b want 0 / 1", {ALUsel, Asel, Bsel, Osel}, reg_reset);
        end
        reset = 0; #1;
        n_checks++;
        if (IRenable !== 1'b1 || reg_reset !== 1'b0) begin
            n_fail++; $display("FAIL reset_fetch: IRenable=%b reg_reset=%b want 1 / 0", IRenable, reg_reset);
        end
    endtask

    task automatic test_addi();
        run_instr(O_IMM, 3'd0, 7'd0, 5'd2, 5'd0, 5'd2, 12'd6, 20'd0, 32'h0, 32'd8, 1'b0, 0, 1, 2, 0);
        n_checks++;
        if ({ob_alusel, ob_asel, ob_bsel} !== {5'd0, 2'd0, 2'd1}) begin
            n_fail++; $display("FAIL addi_sel: ALUsel=%b Asel=%0d Bsel=%0d want 00000/0/1", ob_alusel, ob_asel, ob_bsel);
        end
        n_checks++;
        if (ob_imm !== 32'd6) begin n_fail++; $display("FAIL addi_imm: got %h want 6", ob_imm); end
        n_checks++;
        if (ob_nwr !== 1 || ob_wr_rd !== 5'd2) begin
            n_fail++; $display("FAIL addi_wb: pulses=%0d rdOut=%0d want 1/2", ob_nwr, ob_wr_rd);
        end
        n_checks++;
        if (ob_pc !== 32'd4 || ob_timeout) begin
            n_fail++; $display("FAIL addi_pc: got %h timeout=%b want 4", ob_pc, ob_timeout);
        end
    endtask

    task automatic test_slli();
        run_instr(O_IMM, 3'd1, 7'd0, 5'd3, 5'd0, 5'd4, 12'd6, 20'd0, 32'd1, 32'd3, 1'b0, 2, 0, 0, 0);
        n_checks++;
        if (ob_alusel !== 5'd1 || ob_imm !== 32'd6) begin
            n_fail++; $display("FAIL slli_sel: ALUsel=%b imm=%h want 00001/6", ob_alusel, ob_imm);
        end
        n_checks++;
        if (ob_nwr !== 1 || ob_pc !== 32'd5) begin
            n_fail++; $display("FAIL slli_end: pulses=%0d PCout=%h want 1/5", ob_nwr, ob_pc);
        end
    endtask

    task automatic test_lb();
        run_instr(O_LOAD, 3'd0, 7'd0, 5'd1, 5'd0, 5'd5, 12'h801, 20'd0, 32'h200, 32'h10, 1'b0, 1, 0, 0, 3);
        n_checks++;
        if (ob_imm !== 32'hFFFF_F801) begin n_fail++; $display("FAIL lb_imm: got %h want fffff801", ob_imm); end
        n_checks++;
        if (ob_maddr !== 32'h10 || ob_mrd !== 1'b1 || ob_mwr !== 1'b0 || !ob_mem_held) begin
            n_fail++; $display("FAIL lb_mem: addr=%h rd=%b wr=%b held=%b want 10/1/0/1", ob_maddr, ob_mrd, ob_mwr, ob_mem_held);
        end
        n_checks++;
        if (ob_nwr !== 1 || ob_osel !== 2'd1 || ob_wr_rd !== 5'd5) begin
            n_fail++; $display("FAIL lb_wb: pulses=%0d Osel=%0d rdOut=%0d want 1/1/5", ob_nwr, ob_osel, ob_wr_rd);
        end
    endtask

    task automatic test_beq();
        for (int t = 0; t < 2; t++) begin
            logic [31:0] want;
            want = (t == 0) ? 32'h108 : 32'h104;
            run_instr(O_BR, 3'd0, 7'd0, 5'd1, 5'd2, 5'd7, 12'h004, 20'd0, 32'h100, 32'd0,
                      (t == 0), 0, 1, 1, 0);
            n_checks++;
            if (ob_alusel !== 5'b01000 || ob_bsel !== 2'd0) begin
                n_fail++; $display("FAIL beq_sel[%0d]: ALUsel=%b Bsel=%0d want 01000/0", t, ob_alusel, ob_bsel);
            end
            n_checks++;
            if (ob_pc !== want || ob_nwr !== 0) begin
                n_fail++; $display("FAIL beq_pc[%0d]: PCout=%h writes=%0d want %h/0", t, ob_pc, ob_nwr, want);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [6:0] o, f7; logic [2:0] f3; logic [4:0] a, b, d;
            logic [11:0] i12; logic [19:0] ihi; logic [31:0] pc, ar, eimm, epc; logic z, ewr, is_mem;
            int f3s;
            o = kind2op($urandom_range(0, 9));
            f3 = 3'($urandom_range(0, 7));
            if (o == O_BR) begin
                f3s = $urandom_range(0, 5);
                f3 = 3'((f3s < 2) ? f3s : f3s + 2);
            end
            f7 = $urandom_range(0, 1) ? 7'h20 : 7'h00;
            a = 5'($urandom); b = 5'($urandom);
            d = (n % 8 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            i12 = 12'($urandom); ihi = 20'($urandom);
            pc = $urandom; ar = $urandom; z = 1'($urandom);
            run_instr(o, f3, f7, a, b, d, i12, ihi, pc, ar, z,
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            eimm = m_imm(o, f3, i12, ihi);
            epc = known(o) ? m_pc(o, f3, eimm, pc, ar, z) : pc + 32'd4;
            ewr = known(o) && m_writes(o) && d != 5'd0;
            is_mem = (o == O_LOAD || o == O_STORE);
            n_checks++;
            if (!ob_start || ob_timeout || !ob_dec_quiet || ob_stray) begin
                n_fail++; $display("FAIL rnd_flow[%0d] op=%b: start=%b timeout=%b decquiet=%b stray=%b want 1/0/1/0",
                    n, o, ob_start, ob_timeout, ob_dec_quiet, ob_stray);
            end
            n_checks++;
            if (ob_pc !== epc) begin
                n_fail++; $display("FAIL rnd_pc[%0d] op=%b f3=%0d z=%b: got %h want %h", n, o, f3, z, ob_pc, epc);
            end
            n_checks++;
            if (ob_nwr !== (ewr ? 1 : 0)) begin
                n_fail++; $display("FAIL rnd_wcount[%0d] op=%b rd=%0d: got %0d want %0d", n, o, d, ob_nwr, ewr);
            end
            if (ewr) begin
                n_checks++;
                if (ob_wr_rd !== d || ob_osel !== m_osel(o)) begin
                    n_fail++; $display("FAIL rnd_wb[%0d] op=%b: rdOut=%0d Osel=%0d want %0d/%0d",
                        n, o, ob_wr_rd, ob_osel, d, m_osel(o));
                end
            end
            if (known(o)) begin
                n_checks++;
                if (ob_imm !== eimm || ob_rs1 !== a || ob_rs2 !== b) begin
                    n_fail++; $display("FAIL rnd_latch[%0d] op=%b: imm=%h rs1=%0d rs2=%0d want %h/%0d/%0d",
                        n, o, ob_imm, ob_rs1, ob_rs2, eimm, a, b);
                end
            end
            if (known(o) && o != O_JAL) begin
                n_checks++;
                if ({ob_alusel, ob_asel, ob_bsel} !== {m_alusel(o, f3, f7), m_asel(o), m_bsel(o)}
                    || !ob_oper || !ob_exec_stable) begin
                    n_fail++; $display("FAIL rnd_exec[%0d] op=%b f3=%0d: sel=%b/%0d/%0d oper=%b stable=%b want %b/%0d/%0d",
                        n, o, f3, ob_alusel, ob_asel, ob_bsel, ob_oper, ob_exec_stable,
                        m_alusel(o, f3, f7), m_asel(o), m_bsel(o));
                end
            end
            if (is_mem) begin
                n_checks++;
                if (ob_maddr !== ar || ob_mrd !== (o == O_LOAD) || ob_mwr !== (o == O_STORE)
                    || ob_rsel !== (o == O_STORE) || !ob_mem_held) begin
                    n_fail++; $display("FAIL rnd_mem[%0d] op=%b: addr=%h rd=%b wr=%b rsel=%b held=%b want addr %h",
                        n, o, ob_maddr, ob_mrd, ob_mwr, ob_rsel, ob_mem_held, ar);
                end
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        int nw;
        op = O_LOAD; funct3 = 0; funct7 = 0; rs1 = 5'd1; rd = 5'd9; imm12 = 12'h010;
        PCin = 32'h40; ALURes = 32'h80;
        decodeComplete = 1; dataReady = 1; ALUcomplete = 1; mem_ack = 0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (mem_read !== 1'b1 || mem_address !== 32'h80) begin
            n_fail++; $display("FAIL rstmem_entry: mem_read=%b addr=%h want 1/80", mem_read, mem_address);
        end
        reset = 1; #1;
        n_checks++;
        if (mem_read !== 1'b0 || rdWrite !== 1'b0 || reg_reset !== 1'b1) begin
            n_fail++; $display("FAIL rstmem_strobe: mem_read=%b rdWrite=%b reg_reset=%b want 0/0/1", mem_read, rdWrite, reg_reset);
        end
        n_checks++;
        if (PCout !== 32'd0 || mem_address !== 32'd0) begin
            n_fail++; $display("FAIL rstmem_regs: PCout=%h addr=%h want 0/0", PCout, mem_address);
        end
        @(negedge clk);
        reset = 0; decodeComplete = 0; dataReady = 0; ALUcomplete = 0;
        nw = 0;
        repeat (4) begin
            @(negedge clk);
            if (rdWrite || mem_read) nw++;
        end
        n_checks++;
        if (nw !== 0) begin n_fail++; $display("FAIL rstmem_after: strobes seen %0d want 0", nw); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_slli();
        test_lb();
        test_beq();
        test_random();
        test_reset_mid_mem();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
